// File: rtl/mx_e5m2_quantizer.sv
// MX block quantizer: collects BLOCK_SIZE FP16 elements, derives a shared
// E8M0 scale from the largest finite exponent, then streams the block back
// out as E5M2 elements (round-to-nearest-even, saturating) with that scale.
module mx_e5m2_quantizer #(
  parameter int BLOCK_SIZE = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [7:0]  out_scale_o,
  output logic [7:0]  out_elem_o,
  output logic        out_last_o
);

  localparam int CW = $clog2(BLOCK_SIZE);
  localparam logic [CW-1:0] LAST_IDX = CW'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SCALE   = 2'd1,
    EMIT    = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   idx_r;
  logic [CW-1:0]   next_idx;
  logic [4:0]      emax_r;
  logic            nan_r;
  logic [7:0]      scale_r;
  logic [7:0]      elem_r;
  logic [15:0]     buffer [BLOCK_SIZE];
  logic [15:0]     elem_src;
  logic [7:0]      elem_conv;
  logic            in_hs;
  logic            out_hs;
  logic            is_last;

  // FP16 -> E5M2 relative to the shared exponent. Exponent arithmetic is
  // modulo 32: the true result always lies in 1..30 because e_in <= emax.
  function automatic logic [7:0] f_convert(input logic [15:0] x,
                                           input logic [4:0]  emax,
                                           input logic        nan);
    logic [4:0] e_out;
    logic       up;
    logic [6:0] rnd;
    logic [7:0] res;
    e_out = x[14:10] + 5'd30 - emax;
    up    = x[7] & ((|x[6:0]) | x[8]);
    rnd   = {e_out, x[9:8]} + {6'd0, up};
    if (nan) begin
      res = 8'h7F;
    end else if (x[14:10] == 5'd0) begin
      res = {x[15], 7'd0};
    end else if (rnd[6:2] == 5'd31) begin
      res = {x[15], 7'h7B};
    end else begin
      res = {x[15], rnd};
    end
    return res;
  endfunction

  // Shared E8M0 scale: NaN/Inf marker, all-zero marker, or E_max + 97.
  function automatic logic [7:0] f_scale(input logic [4:0] emax, input logic nan);
    logic [7:0] res;
    if (nan) begin
      res = 8'hFF;
    end else if (emax == 5'd0) begin
      res = 8'h7F;
    end else begin
      res = {3'd0, emax} + 8'd97;
    end
    return res;
  endfunction

  assign in_ready_o  = (state_r == COLLECT);
  assign out_valid_o = (state_r == EMIT);
  assign is_last     = (idx_r == LAST_IDX);
  assign out_last_o  = out_valid_o && is_last;
  assign out_scale_o = scale_r;
  assign out_elem_o  = elem_r;
  assign in_hs       = in_valid_i && in_ready_o;
  assign out_hs      = out_valid_o && out_ready_i;
  assign next_idx    = is_last ? CW'(0) : idx_r + CW'(1);

  // Select the element to be converted next: element 0 while scaling, else the one after idx.
  always_comb begin
    elem_src = buffer[next_idx];
    if (state_r == SCALE) begin
      elem_src = buffer[0];
    end else begin
      elem_src = buffer[next_idx];
    end
    elem_conv = f_convert(elem_src, emax_r, nan_r);
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= COLLECT;
    end else begin
      state_r <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      COLLECT: begin
        if (in_hs && (cnt_r == LAST_IDX)) begin
          state_nxt = SCALE;
        end else begin
          state_nxt = COLLECT;
        end
      end
      SCALE: state_nxt = EMIT;
      EMIT: begin
        if (out_hs && is_last) begin
          state_nxt = COLLECT;
        end else begin
          state_nxt = EMIT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Element buffer write; contents survive reset since a new block overwrites them.
  always_ff @(posedge clk_i) begin
    if (in_hs) begin
      buffer[cnt_r] <= in_data_i;
    end
  end

  // Counters, block statistics and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r   <= '0;
      idx_r   <= '0;
      emax_r  <= 5'd0;
      nan_r   <= 1'b0;
      scale_r <= 8'h00;
      elem_r  <= 8'h00;
    end else begin
      case (state_r)
        COLLECT: begin
          if (in_hs) begin
            cnt_r <= (cnt_r == LAST_IDX) ? CW'(0) : cnt_r + CW'(1);
            if (in_data_i[14:10] == 5'd31) begin
              nan_r <= 1'b1;
            end else if ((in_data_i[14:10] != 5'd0) && (in_data_i[14:10] > emax_r)) begin
              emax_r <= in_data_i[14:10];
            end
          end
        end
        SCALE: begin
          scale_r <= f_scale(emax_r, nan_r);
          elem_r  <= elem_conv;
          idx_r   <= '0;
        end
        EMIT: begin
          if (out_hs) begin
            if (is_last) begin
              idx_r  <= '0;
              emax_r <= 5'd0;
              nan_r  <= 1'b0;
            end else begin
              idx_r  <= next_idx;
              elem_r <= elem_conv;
            end
          end
        end
        default: begin
          cnt_r <= '0;
          idx_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/mx_e5m2_quantizer.md
MX_E5M2_QUANTIZER -- requirements
Module: mx_e5m2_quantizer

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 32, meaning elements per MX block (legal range 2..64).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port in_valid_i, input, 1, an FP16 element is offered.
REQ-005 SHALL have port in_ready_o, output, 1, the block accepts an element this cycle.
REQ-006 SHALL have port in_data_i, input, 16, FP16 element {sign, exp[4:0], man[9:0]}, bias 15.
REQ-007 SHALL have port out_valid_o, output, 1, the scale and element outputs are valid.
REQ-008 SHALL have port out_ready_i, input, 1, the consumer accepts the current output.
REQ-009 SHALL have port out_scale_o, output, 8, E8M0 shared scale of the block being emitted.
REQ-010 SHALL have port out_elem_o, output, 8, E5M2 element {sign, exp[4:0], man[1:0]}, bias 15.
REQ-011 SHALL have port out_last_o, output, 1, the current output is element BLOCK_SIZE-1 of the block.

Function
REQ-012 SHALL implement FSM states COLLECT, SCALE and EMIT, with reset state COLLECT.
REQ-013 COLLECT: in_ready_o=1; on each in_valid_i&&in_ready_o, store in_data_i into buffer[cnt], increment cnt, and update running max biased exponent E_max over finite inputs with exp in 1..30.
REQ-014 COLLECT SHALL go to SCALE on the handshake with cnt==BLOCK_SIZE-1 and reset cnt to 0.
REQ-015 SCALE SHALL last exactly 1 cycle with in_ready_o=0 and out_valid_o=0, register out_scale_o, then go to EMIT.
REQ-016 Scale rule SHALL be: any input with exp==31 (Inf/NaN) gives scale 0xFF; else E_max==0 (all zero/subnormal) gives 0x7F; else E_max+97 (shared exponent X=E_max-30).
REQ-017 EMIT: out_valid_o=1 and in_ready_o=0; element index advances only on out_valid_o&&out_ready_i; out_last_o=1 exactly when index==BLOCK_SIZE-1.
REQ-018 EMIT SHALL return to COLLECT on the handshake with out_last_o=1; the first new input is accepted the next cycle.
REQ-019 While out_valid_o=1 and out_ready_i=0, out_scale_o, out_elem_o and out_last_o SHALL hold stable.
REQ-020 With scale 0xFF, every element SHALL be emitted as 0x7F.
REQ-021 An FP16 zero or subnormal input (exp==0) SHALL be emitted as {sign,7'b0}.
REQ-022 A normal input SHALL be emitted with biased exponent e_in-E_max+30, always in 1..30, so no E5M2 subnormal output occurs.
REQ-023 Mantissa SHALL be rounded from 10 to 2 bits with round-to-nearest-even (guard=man[7], sticky=|man[6:0]).
REQ-024 A mantissa carry SHALL increment the exponent; result exponent 31 SHALL saturate to {sign,7'b1111011} (±57344).
REQ-025 Output element and scale paths SHALL be registered or driven from registered state only; no combinational path from in_* to out_*.
REQ-026 Counters SHALL be $clog2(BLOCK_SIZE) bits wide and SHALL NOT wrap past BLOCK_SIZE-1.

Reset
REQ-027 On rst_i=1 at a clock edge, the FSM SHALL go to COLLECT, counters and E_max to 0, the NaN flag to 0, out_valid_o=0, out_last_o=0, out_scale_o=0x00, out_elem_o=0x00; in_ready_o=1 from the first cycle after reset deassertion.
REQ-028 Reset in any state, including mid-COLLECT or mid-EMIT, SHALL discard the partial block; buffer contents need not be cleared.

Verification
REQ-029 32 x 0x3C00 (1.0) -> one SCALE cycle, then out_scale_o=0x70 and 32 elements of 0x78, out_last_o only on the 32nd.
REQ-030 Block with max 0x3C00 plus 0x3800, 0x3E00, 0xBC00, 0x3C80, 0x3D80 -> elements 0x74, 0x7A, 0xF8, 0x78 (tie to even), 0x7A (tie rounded up).
REQ-031 Block with max 0x3FFF -> scale 0x70; that element saturates to 0x7B.
REQ-032 All inputs 0x0000 except one 0x8000 and one 0x0001 -> scale 0x7F; elements 0x00, 0x80 and 0x00 respectively.
REQ-033 NaN 0x7E00 at index 5 -> scale 0xFF; all 32 elements 0x7F.
REQ-034 Reset after 10 accepted inputs, then a fresh block -> only the fresh block is emitted; holding out_ready_i=0 for 5 cycles mid-EMIT -> outputs stable, with no element lost or duplicated.
